// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter controller: register offsets,
// supported baud rates, serializer states and small helper functions.
package uart_pkg;

  localparam logic [11:0] OFF_DATA   = 12'h000;
  localparam logic [11:0] OFF_BUSY   = 12'h004;
  localparam logic [11:0] OFF_BAUD   = 12'h008;
  localparam logic [11:0] OFF_PARITY = 12'h00C;
  localparam logic [11:0] OFF_STOP   = 12'h010;
  localparam logic [11:0] OFF_RST    = 12'h024;

  localparam logic [31:0] BAUD_9600   = 32'd9600;
  localparam logic [31:0] BAUD_19200  = 32'd19200;
  localparam logic [31:0] BAUD_38400  = 32'd38400;
  localparam logic [31:0] BAUD_57600  = 32'd57600;
  localparam logic [31:0] BAUD_115200 = 32'd115200;

  typedef enum logic [2:0] {
    SER_IDLE   = 3'd0,
    SER_START  = 3'd1,
    SER_DATA   = 3'd2,
    SER_PARITY = 3'd3,
    SER_STOP   = 3'd4
  } ser_state_e;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic baud_supported(input logic [31:0] baud);
    logic ok;
    case (baud)
      BAUD_9600, BAUD_19200, BAUD_38400, BAUD_57600, BAUD_115200: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // A zero divisor would stall the serializer forever, so clamp to one clock.
  function automatic logic [31:0] bit_divisor(input logic [31:0] clk_hz, input logic [31:0] baud);
    logic [31:0] q;
    q = clk_hz / baud;
    if (q == 32'd0) begin
      q = 32'd1;
    end else begin
      q = q;
    end
    return q;
  endfunction

endpackage

// File: rtl/uart_tx_sb_ctrl_if.sv
// System-bus slave port of the UART transmitter controller.
interface uart_tx_sb_ctrl_if;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;

  modport master (output req_i, output write_enable_i, output addr_i,
                  output write_data_i, input read_data_o);
  modport slave  (input req_i, input write_enable_i, input addr_i,
                  input write_data_i, output read_data_o);
endinterface

// File: rtl/uart_tx_serializer.sv
// Bit serializer: start, 8 data bits LSB first, optional even parity, 1 or 2
// stop bits, each held for the latched divisor; tx is registered.
module uart_tx_serializer
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srst,
  input  logic        start,
  input  logic [7:0]  data,
  input  logic [31:0] divisor,
  input  logic        parity_en,
  input  logic [1:0]  stopbit,
  output logic        tx_o,
  output logic        busy,
  output logic        last
);

  ser_state_e  state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] div_r, div_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic        stop_idx_r, stop_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic        par_r, par_s;
  logic        par_en_r, par_en_s;
  logic        two_stop_r, two_stop_s;
  logic        tx_r, tx_s;
  logic        tick_s, last_s, load_s;

  assign tick_s = (cnt_r == (div_r - 32'd1));
  assign last_s = (state_r == SER_STOP) && tick_s && (stop_idx_r == two_stop_r);
  // A new frame may start from idle or directly on the final stop-bit clock.
  assign load_s = start && ((state_r == SER_IDLE) || last_s);

  assign tx_o = tx_r;
  assign busy = (state_r != SER_IDLE);
  assign last = last_s;

  // Next-state and next-datapath logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_s      = div_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    par_s      = par_r;
    par_en_s   = par_en_r;
    two_stop_s = two_stop_r;
    tx_s       = tx_r;
    if (load_s) begin
      state_s    = SER_START;
      cnt_s      = 32'd0;
      div_s      = divisor;
      shift_s    = data;
      par_s      = even_parity(data);
      par_en_s   = parity_en;
      two_stop_s = (stopbit == 2'd2);
      tx_s       = 1'b0;
    end else begin
      case (state_r)
        SER_IDLE: begin
          cnt_s = 32'd0;
          tx_s  = 1'b1;
        end
        SER_START: begin
          if (tick_s) begin
            cnt_s     = 32'd0;
            state_s   = SER_DATA;
            bit_idx_s = 3'd0;
            tx_s      = shift_r[0];
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        SER_DATA: begin
          if (tick_s) begin
            cnt_s   = 32'd0;
            shift_s = {1'b0, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              if (par_en_r) begin
                state_s = SER_PARITY;
                tx_s    = par_r;
              end else begin
                state_s    = SER_STOP;
                stop_idx_s = 1'b0;
                tx_s       = 1'b1;
              end
            end else begin
              bit_idx_s = bit_idx_r + 3'd1;
              tx_s      = shift_r[1];
            end
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        SER_PARITY: begin
          if (tick_s) begin
            cnt_s      = 32'd0;
            state_s    = SER_STOP;
            stop_idx_s = 1'b0;
            tx_s       = 1'b1;
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        SER_STOP: begin
          if (tick_s) begin
            cnt_s = 32'd0;
            if (last_s) begin
              state_s = SER_IDLE;
              tx_s    = 1'b1;
            end else begin
              stop_idx_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        default: begin
          state_s = SER_IDLE;
          cnt_s   = 32'd0;
          tx_s    = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers; soft reset mirrors the hardware reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SER_IDLE;
      cnt_r      <= 32'd0;
      div_r      <= 32'd1;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      par_en_r   <= 1'b0;
      two_stop_r <= 1'b0;
      tx_r       <= 1'b1;
    end else if (srst) begin
      state_r    <= SER_IDLE;
      cnt_r      <= 32'd0;
      div_r      <= 32'd1;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'd0;
      par_r      <= 1'b0;
      par_en_r   <= 1'b0;
      two_stop_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_r      <= div_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      par_r      <= par_s;
      par_en_r   <= par_en_s;
      two_stop_r <= two_stop_s;
      tx_r       <= tx_s;
    end
  end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// Memory-mapped UART transmitter: bus decode, TX config registers, read mux.
// Optional one-byte holding register enabled by macro UART_TX_HOLD_BUF_EN.
module uart_tx_sb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 32'd10_000_000,
  parameter int unsigned DEFAULT_BAUD = 32'd9600
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  uart_tx_sb_ctrl_if.slave  bus,
  output logic              tx_o
);

  localparam logic [31:0] DIV_9600    = bit_divisor(CLK_HZ, BAUD_9600);
  localparam logic [31:0] DIV_19200   = bit_divisor(CLK_HZ, BAUD_19200);
  localparam logic [31:0] DIV_38400   = bit_divisor(CLK_HZ, BAUD_38400);
  localparam logic [31:0] DIV_57600   = bit_divisor(CLK_HZ, BAUD_57600);
  localparam logic [31:0] DIV_115200  = bit_divisor(CLK_HZ, BAUD_115200);
  localparam logic [31:0] DIV_DEFAULT = bit_divisor(CLK_HZ, DEFAULT_BAUD);
  localparam logic [31:0] BAUD_RESET  = DEFAULT_BAUD;

  logic [11:0] off_s;
  logic        wr_s, rd_s, srst_s, data_we_s, cfg_ok_s;
  logic        baud_we_s, parity_we_s, stop_we_s;
  logic        busy_s, ser_busy_s, ser_last_s, ser_start_s;
  logic [7:0]  ser_byte_s;
  logic [31:0] divisor_s, rd_mux_s;
  logic [31:0] baud_r, read_data_r;
  logic        parity_en_r;
  logic [1:0]  stopbit_r;
  logic        unused_addr_s;

  assign off_s         = bus.addr_i[11:0];
  assign unused_addr_s = ^bus.addr_i[31:12];
  assign wr_s          = bus.req_i && bus.write_enable_i;
  assign rd_s          = bus.req_i && !bus.write_enable_i;
  assign srst_s        = wr_s && (off_s == OFF_RST) && bus.write_data_i[0];
  assign data_we_s     = wr_s && (off_s == OFF_DATA);
  assign cfg_ok_s      = wr_s && !busy_s;
  assign baud_we_s     = cfg_ok_s && (off_s == OFF_BAUD) && baud_supported(bus.write_data_i);
  assign parity_we_s   = cfg_ok_s && (off_s == OFF_PARITY);
  assign stop_we_s     = cfg_ok_s && (off_s == OFF_STOP) &&
                         ((bus.write_data_i[1:0] == 2'd1) || (bus.write_data_i[1:0] == 2'd2));
  assign bus.read_data_o = read_data_r;

`ifdef UART_TX_HOLD_BUF_EN
  logic [7:0] hold_r;
  logic       hold_full_r, fill_s, feed_s, direct_s;

  assign busy_s      = ser_busy_s || hold_full_r;
  assign direct_s    = data_we_s && !busy_s;
  assign fill_s      = data_we_s && ser_busy_s && !hold_full_r;
  // Feeding on the last stop clock chains the next START with no idle gap.
  assign feed_s      = hold_full_r && (!ser_busy_s || ser_last_s);
  assign ser_start_s = direct_s || feed_s;
  assign ser_byte_s  = feed_s ? hold_r : bus.write_data_i[7:0];

  // Holding register for one byte queued behind the frame being shifted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_r      <= 8'd0;
      hold_full_r <= 1'b0;
    end else if (srst_s) begin
      hold_r      <= 8'd0;
      hold_full_r <= 1'b0;
    end else if (fill_s) begin
      hold_r      <= bus.write_data_i[7:0];
      hold_full_r <= 1'b1;
    end else if (feed_s) begin
      hold_full_r <= 1'b0;
    end
  end
`else
  logic unused_last_s;

  assign unused_last_s = ser_last_s;
  assign busy_s        = ser_busy_s;
  assign ser_start_s   = data_we_s && !busy_s;
  assign ser_byte_s    = bus.write_data_i[7:0];
`endif

  // Bit-period divisor for the currently configured baud rate.
  always_comb begin
    divisor_s = DIV_DEFAULT;
    case (baud_r)
      BAUD_9600:   divisor_s = DIV_9600;
      BAUD_19200:  divisor_s = DIV_19200;
      BAUD_38400:  divisor_s = DIV_38400;
      BAUD_57600:  divisor_s = DIV_57600;
      BAUD_115200: divisor_s = DIV_115200;
      default:     divisor_s = DIV_DEFAULT;
    endcase
  end

  // Read mux; write-only and unmapped offsets read as zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (off_s)
      OFF_BUSY:   rd_mux_s = {31'd0, busy_s};
      OFF_BAUD:   rd_mux_s = baud_r;
      OFF_PARITY: rd_mux_s = {31'd0, parity_en_r};
      OFF_STOP:   rd_mux_s = {30'd0, stopbit_r};
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Configuration and read-data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      baud_r      <= BAUD_RESET;
      parity_en_r <= 1'b1;
      stopbit_r   <= 2'd1;
      read_data_r <= 32'd0;
    end else if (srst_s) begin
      baud_r      <= BAUD_RESET;
      parity_en_r <= 1'b1;
      stopbit_r   <= 2'd1;
      read_data_r <= 32'd0;
    end else begin
      if (baud_we_s) begin
        baud_r <= bus.write_data_i;
      end
      if (parity_we_s) begin
        parity_en_r <= bus.write_data_i[0];
      end
      if (stop_we_s) begin
        stopbit_r <= bus.write_data_i[1:0];
      end
      if (rd_s) begin
        read_data_r <= rd_mux_s;
      end
    end
  end

  uart_tx_serializer u_serializer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .srst      (srst_s),
    .start     (ser_start_s),
    .data      (ser_byte_s),
    .divisor   (divisor_s),
    .parity_en (parity_en_r),
    .stopbit   (stopbit_r),
    .tx_o      (tx_o),
    .busy      (ser_busy_s),
    .last      (ser_last_s)
  );

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Self-checking bench for uart_tx_sb_ctrl: random frames compared against a
// bit-list model of the serial line; honours UART_TX_HOLD_BUF_EN.
module tb_uart_tx_sb_ctrl;

  localparam int CLK_HZ = 10_000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int   errors = 0;
  int   checks = 0;

  bit exp_bits[$];
  int exp_div;

  always #5 clk = ~clk;

  uart_tx_sb_ctrl_if bus ();

  uart_tx_sb_ctrl #(.CLK_HZ(CLK_HZ), .DEFAULT_BAUD(9600)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus),
    .tx_o  (tx)
  );

  function automatic int div_of(input int baud);
    return CLK_HZ / baud;
  endfunction

  // Expected line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] d, input bit pen, input int nstop);
    exp_bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
    if (pen) exp_bits.push_back(bit'($countones(d) % 2));
    for (int k = 0; k < nstop; k++) exp_bits.push_back(1'b1);
  endfunction

  task automatic bus_write(input logic [11:0] off, input logic [31:0] data);
    bus.req_i = 1'b1; bus.write_enable_i = 1'b1;
    bus.addr_i = 32'h8000_5000 | {20'h0, off}; bus.write_data_i = data;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.write_enable_i = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] off, output logic [31:0] data);
    bus.req_i = 1'b1; bus.write_enable_i = 1'b0;
    bus.addr_i = 32'h8000_5000 | {20'h0, off};
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    data = bus.read_data_o;
  endtask

  task automatic set_cfg(input int baud, input bit pen, input int nstop);
    bus_write(12'h008, baud);
    bus_write(12'h00C, {31'd0, pen});
    bus_write(12'h010, nstop);
  endtask

  // Compares tx every cycle against exp_bits; reads busy on the final cycle.
  task automatic check_wave(input string name, input int start_off, input logic exp_busy_last);
    int total, bad, first;
    logic first_tx;
    total = exp_bits.size() * exp_div;
    bad = 0; first = -1; first_tx = 1'b0;
    for (int i = start_off; i < total; i++) begin
      if (tx !== exp_bits[i / exp_div]) begin
        if (bad == 0) begin first = i; first_tx = tx; end
        bad++;
      end
      if (i == total - 1) begin
        bus.req_i = 1'b1; bus.write_enable_i = 1'b0; bus.addr_i = 32'h8000_5004;
      end
      @(posedge clk); #1;
    end
    bus.req_i = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_wave: %0d wrong cycles, first at cycle %0d tx=%b, required 0 wrong", name, bad, first, first_tx);
    end
    checks++;
    if (bus.read_data_o !== {31'd0, exp_busy_last}) begin
      errors++;
      $display("FAIL %s_busy_last: got %0d, required %0d", name, bus.read_data_o, exp_busy_last);
    end
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: tx=%b, required 1", name, tx);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [11:0] offs [6];
    logic [31:0] exps [6];
    offs = '{12'h008, 12'h00C, 12'h010, 12'h004, 12'h000, 12'h014};
    exps = '{32'd9600, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    bus.req_i = 1'b0; bus.write_enable_i = 1'b0; bus.addr_i = 32'd0; bus.write_data_i = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx); end
    checks++;
    if (bus.read_data_o !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0d, required 0", bus.read_data_o); end
    for (int i = 0; i < 6; i++) begin
      bus_read(offs[i], rd);
      checks++;
      if (rd !== exps[i]) begin
        errors++;
        $display("FAIL reset_reg_%0h: got %0d, required %0d", offs[i], rd, exps[i]);
      end
    end
  endtask

  task automatic test_default_frame();
    logic [31:0] rd;
    exp_bits.delete(); exp_div = div_of(9600);
    build_frame(8'h55, 1'b1, 1);
    bus_write(12'h000, 32'h55);
    check_wave("default_55", 0, 1'b1);
    bus_read(12'h004, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL default_busy_after: got %0d, required 0", rd); end
  endtask

  task automatic test_config();
    logic [31:0] rd;
    set_cfg(115200, 1'b0, 2);
    bus_read(12'h008, rd); checks++;
    if (rd !== 32'd115200) begin errors++; $display("FAIL cfg_baud: got %0d, required 115200", rd); end
    bus_read(12'h00C, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL cfg_parity: got %0d, required 0", rd); end
    bus_write(12'h008, 32'd12345);
    bus_write(12'h010, 32'd3);
    bus_write(12'h010, 32'd0);
    bus_write(12'h004, 32'd1);
    bus_read(12'h008, rd); checks++;
    if (rd !== 32'd115200) begin errors++; $display("FAIL cfg_bad_baud: got %0d, required 115200", rd); end
    // Read data must hold across a later write.
    bus_write(12'h00C, 32'd0);
    checks++;
    if (bus.read_data_o !== 32'd115200) begin errors++; $display("FAIL cfg_rdata_hold: got %0d, required 115200", bus.read_data_o); end
    bus_read(12'h010, rd); checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL cfg_bad_stop: got %0d, required 2", rd); end
    bus_read(12'h004, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL cfg_busy_ro: got %0d, required 0", rd); end
    bus_read(12'h024, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL cfg_rst_wo: got %0d, required 0", rd); end
    exp_bits.delete(); exp_div = div_of(115200);
    build_frame(8'hA3, 1'b0, 2);
    bus_write(12'h000, 32'hA3);
    check_wave("fast_a3", 0, 1'b1);
  endtask

  task automatic test_busy_reject();
    logic [31:0] rd;
    bit idle;
    set_cfg(115200, 1'b0, 1);
    bus_write(12'h000, 32'h5A);
    bus_write(12'h008, 32'd19200);
    bus_write(12'h00C, 32'd1);
    bus_write(12'h010, 32'd2);
    idle = 1'b0;
    for (int n = 0; n < 5000 && !idle; n++) begin
      bus_read(12'h004, rd);
      idle = (rd == 32'd0);
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL busy_wait_idle: busy=1 after 5000 reads, required 0"); end
    bus_read(12'h008, rd); checks++;
    if (rd !== 32'd115200) begin errors++; $display("FAIL busy_baud: got %0d, required 115200", rd); end
    bus_read(12'h00C, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL busy_parity: got %0d, required 0", rd); end
    bus_read(12'h010, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL busy_stop: got %0d, required 1", rd); end
  endtask

  task automatic test_random_frames();
    int bauds [5];
    int baud, nstop;
    bit pen;
    logic [7:0] d;
    bauds = '{9600, 19200, 38400, 57600, 115200};
    for (int n = 0; n < 5; n++) begin
      baud  = bauds[$urandom_range(4, 1)];
      pen   = 1'($urandom_range(1, 0));
      nstop = $urandom_range(2, 1);
      d     = 8'($urandom());
      set_cfg(baud, pen, nstop);
      exp_bits.delete(); exp_div = div_of(baud);
      build_frame(d, pen, nstop);
      bus_write(12'h000, {24'd0, d});
      check_wave($sformatf("rand%0d_b%0d", n, baud), 0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    set_cfg(115200, 1'b1, 1);
    exp_bits.delete(); exp_div = div_of(115200);
    build_frame(8'h01, 1'b1, 1);
`ifdef UART_TX_HOLD_BUF_EN
    build_frame(8'h02, 1'b1, 1);
`else
    for (int k = 0; k < 11; k++) exp_bits.push_back(1'b1);
`endif
    bus_write(12'h000, 32'h01);
    bus_write(12'h000, 32'h02);
`ifdef UART_TX_HOLD_BUF_EN
    check_wave("b2b", 1, 1'b1);
`else
    check_wave("b2b", 1, 1'b0);
`endif
    bus_read(12'h004, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL b2b_busy_after: got %0d, required 0", rd); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] rd;
    int bad;
    set_cfg(57600, 1'b0, 2);
    bus_write(12'h000, 32'h00);
    repeat ($urandom_range(1000, 200)) begin @(posedge clk); #1; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL srst_pre_tx: got %b, required 0", tx); end
    bus_write(12'h024, 32'd0);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL srst_zero_tx: got %b, required 0", tx); end
    bus_read(12'h004, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL srst_zero_busy: got %0d, required 1", rd); end
    bus_write(12'h024, 32'd1);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL srst_tx: got %b, required 1", tx); end
    checks++;
    if (bus.read_data_o !== 32'd0) begin errors++; $display("FAIL srst_rdata: got %0d, required 0", bus.read_data_o); end
    bus_read(12'h008, rd); checks++;
    if (rd !== 32'd9600) begin errors++; $display("FAIL srst_baud: got %0d, required 9600", rd); end
    bus_read(12'h00C, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL srst_parity: got %0d, required 1", rd); end
    bus_read(12'h010, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL srst_stop: got %0d, required 1", rd); end
    bus_read(12'h004, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL srst_busy: got %0d, required 0", rd); end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      if (tx !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL srst_no_resume: %0d low cycles, required 0", bad); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    int bad;
    set_cfg(115200, 1'b1, 1);
    bus_read(12'h008, rd);
    bus_write(12'h000, 32'h00);
    repeat (300) begin @(posedge clk); #1; end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL arst_pre_tx: got %b, required 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL arst_tx: got %b, required 1", tx); end
    checks++;
    if (bus.read_data_o !== 32'd0) begin errors++; $display("FAIL arst_rdata: got %0d, required 0", bus.read_data_o); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read(12'h008, rd); checks++;
    if (rd !== 32'd9600) begin errors++; $display("FAIL arst_baud: got %0d, required 9600", rd); end
    bus_read(12'h004, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL arst_busy: got %0d, required 0", rd); end
    bad = 0;
    for (int i = 0; i < 1200; i++) begin
      if (tx !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL arst_no_resume: %0d low cycles, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_config();
    test_busy_reject();
    test_random_frames();
    test_back_to_back();
    test_soft_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
